// File: rtl/addsub_arbiter.sv
// Round-robin arbiter/sequencer granting two requesters access to a shared 16-bit add/sub unit.
// Latency: handshake at t, ISSUE at t+1, respN_valid at t+2; one op in flight, 1 op per 3 cycles peak.
// Backpressure: reqN_ready only in IDLE; a stalled response holds RESP and blocks all new requests.
module addsub_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_sub,
    input  logic             req1_sub,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_overflow,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_sub,
    input  logic [WIDTH-1:0] adder_result,
    input  logic             adder_overflow,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;
    logic   rr;
    logic   owner;
    logic   grantCh;
    logic   reqFire;
    logic   respFire;
    logic   ovfSat;

    // Single requester wins outright; on contention the rr pointer decides.
    assign grantCh = (req0_valid && req1_valid) ? rr : req1_valid;
    assign ovfSat  = (ovf_count == {CNT_W{1'b1}});

    always_comb begin
        stateNext   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        reqFire     = 1'b0;
        respFire    = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !grantCh;
                req1_ready = req1_valid && grantCh;
                reqFire    = req0_valid || req1_valid;
                if (reqFire) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                stateNext = RESP;
            end
            RESP: begin
                resp0_valid = !owner;
                resp1_valid = owner;
                respFire    = owner ? resp1_ready : resp0_ready;
                if (respFire) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr            <= 1'b0;
            owner         <= 1'b0;
            adder_a       <= '0;
            adder_b       <= '0;
            adder_sub     <= 1'b0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
        end else begin
            state <= stateNext;
            if (reqFire) begin
                adder_a   <= grantCh ? req1_a : req0_a;
                adder_b   <= grantCh ? req1_b : req0_b;
                adder_sub <= grantCh ? req1_sub : req0_sub;
                owner     <= grantCh;
                rr        <= !grantCh;
            end
            // The unit's outputs are only meaningful while ISSUE holds its operands.
            if (state == ISSUE) begin
                resp_result   <= adder_result;
                resp_overflow <= adder_overflow;
            end
        end
    end

    // A clear coinciding with an overflowing op leaves that op counted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ovf_count <= '0;
        end else if (state == ISSUE && adder_overflow) begin
            if (stat_clear) begin
                ovf_count <= CNT_W'(1);
            end else if (!ovfSat) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (stat_clear) begin
            ovf_count <= '0;
        end
    end

endmodule
